aes_byte_loader: RTL and testbench

Byte-serial front end for the AES encryption core. Accepts key bytes and plaintext bytes over one 8-bit valid/ready stream. Assembles them into a held key register and a 128-bit block, then presents block and key to the combinational encryption stage over a valid/ready handshake. Sits directly upstream of the encryptor; its `blk_data`/`blk_key` drive the encryptor's `in`/`key` inputs.

---
 rtl/aes_pkg.sv | 19 +
 rtl/aes_byte_shreg.sv | 31 +++
 rtl/aes_byte_loader.sv | 116 +++++++++++
 tb/tb_aes_byte_loader.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES types and size helpers used by the byte loader and its shift registers.
package aes_pkg;

  localparam int BLK_BYTES = 16;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } loader_state_t;

  function automatic int key_bytes(input int n);
    return (2 * n + 2) * 4;
  endfunction

  function automatic int key_bits(input int n);
    return key_bytes(n) * 8;
  endfunction

endpackage

// File: rtl/aes_byte_shreg.sv
// MSB-first byte shift register: each enabled byte enters at the bottom, so the
// first byte loaded ends up in the top byte lane once the register is full.
module aes_byte_shreg #(
  parameter int W = 128
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [7:0]   din,
  output logic [W-1:0] dout
);

  logic [W-1:0] sh_q;
  logic [W-1:0] sh_d;

  always_comb begin
    sh_d = sh_q;
    if (clr) begin
      sh_d = '0;
    end else if (en) begin
      sh_d = {sh_q[W-9:0], din};
    end
  end

  always_ff @(posedge clk) begin
    sh_q <= sh_d;
  end

  assign dout = sh_q;

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-serial key/plaintext loader feeding the combinational AES stage: gathers
// a held key and a 16-byte block, then offers both downstream until accepted.
module aes_byte_loader
  import aes_pkg::*;
#(
  parameter int  N     = 1,
  localparam int KEY_W = key_bits(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_key,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [127:0]     blk_data,
  output logic [KEY_W-1:0] blk_key,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic             key_ok
);

  localparam int KEY_BYTES = key_bytes(N);
  localparam int KCNT_W    = $clog2(KEY_BYTES);
  localparam int DCNT_W    = $clog2(BLK_BYTES);
  localparam logic [KCNT_W-1:0] KCNT_LAST = KCNT_W'(KEY_BYTES - 1);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(BLK_BYTES - 1);

  loader_state_t     state_q, state_d;
  logic [KCNT_W-1:0] kcnt_q, kcnt_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic              key_ok_q, key_ok_d;
  logic              key_acc;
  logic              data_acc;

  // Both ports use the same rule: a transfer happens on exactly the rising edge
  // where valid && ready are both high; the sender holds its payload until then
  // and the receiver never makes ready depend on its own downstream ready.
  // Keys are refused while a block is half filled so a block never mixes keys.
  always_comb begin
    in_ready = 1'b0;
    if (!rst && state_q == FILL) begin
      in_ready = in_key ? (dcnt_q == '0) : key_ok_q;
    end
  end

  assign key_acc  = in_valid && in_ready && in_key;
  assign data_acc = in_valid && in_ready && !in_key;

  always_comb begin
    state_d  = state_q;
    kcnt_d   = kcnt_q;
    dcnt_d   = dcnt_q;
    key_ok_d = key_ok_q;

    if (key_acc) begin
      kcnt_d = (kcnt_q == KCNT_LAST) ? '0 : kcnt_q + 1'b1;
      if (kcnt_q == KCNT_LAST) begin
        key_ok_d = 1'b1;
      end else if (kcnt_q == '0) begin
        key_ok_d = 1'b0;
      end
    end

    if (data_acc) begin
      dcnt_d = (dcnt_q == DCNT_LAST) ? '0 : dcnt_q + 1'b1;
    end

    case (state_q)
      FILL: begin
        if (data_acc && dcnt_q == DCNT_LAST) begin
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (blk_ready) begin
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= FILL;
      kcnt_q   <= '0;
      dcnt_q   <= '0;
      key_ok_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      kcnt_q   <= kcnt_d;
      dcnt_q   <= dcnt_d;
      key_ok_q <= key_ok_d;
    end
  end

  aes_byte_shreg #(.W(128)) u_data_sr (
    .clk  (clk),
    .clr  (rst),
    .en   (data_acc),
    .din  (in_data),
    .dout (blk_data)
  );

  aes_byte_shreg #(.W(KEY_W)) u_key_sr (
    .clk  (clk),
    .clr  (rst),
    .en   (key_acc),
    .din  (in_data),
    .dout (blk_key)
  );

  assign blk_valid = (state_q == HOLD);
  assign key_ok    = key_ok_q;

endmodule

// File: tb/tb_aes_byte_loader.sv
// Bench for aes_byte_loader: directed FIPS-197 and corner cases plus randomized
// traffic on an N=1 instance, and a directed AES-256 key load on an N=3 instance.
module tb_aes_byte_loader;

  localparam int KB1 = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst = 1'b1;
  logic [7:0]   in_data = '0;
  logic         in_key = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] blk_data;
  logic [127:0] blk_key;
  logic         blk_valid;
  logic         blk_ready = 1'b0;
  logic         key_ok;

  logic         rst_3 = 1'b1;
  logic [7:0]   in_data_3 = '0;
  logic         in_key_3 = 1'b0;
  logic         in_valid_3 = 1'b0;
  logic         in_ready_3;
  logic [127:0] blk_data_3;
  logic [255:0] blk_key_3;
  logic         blk_valid_3;
  logic         blk_ready_3 = 1'b0;
  logic         key_ok_3;

  aes_byte_loader #(.N(1)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_key    (in_key),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .blk_data  (blk_data),
    .blk_key   (blk_key),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .key_ok    (key_ok)
  );

  aes_byte_loader #(.N(3)) u_dut3 (
    .clk       (clk),
    .rst       (rst_3),
    .in_data   (in_data_3),
    .in_key    (in_key_3),
    .in_valid  (in_valid_3),
    .in_ready  (in_ready_3),
    .blk_data  (blk_data_3),
    .blk_key   (blk_key_3),
    .blk_valid (blk_valid_3),
    .blk_ready (blk_ready_3),
    .key_ok    (key_ok_3)
  );

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_miss = 0;

  logic [255:0] exp_q[$];      // {block, key} expected at each downstream handshake
  logic [7:0]   m_key_cur[$];  // key bytes of the key currently being loaded
  logic [7:0]   m_data[$];     // plaintext bytes of the block being filled
  logic [127:0] m_key_full;
  bit           m_key_ok;
  bit           m_hold;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] key_cur_val();
    logic [127:0] v = '0;
    for (int i = 0; i < m_key_cur.size(); i++) v = {v[119:0], m_key_cur[i]};
    return v;
  endfunction

  function automatic logic [127:0] data_val();
    logic [127:0] v = '0;
    for (int i = 0; i < m_data.size(); i++) v = {v[119:0], m_data[i]};
    return v;
  endfunction

  function automatic bit pred_ready(input bit k);
    return !m_hold && (k ? (m_data.size() == 0) : m_key_ok);
  endfunction

  task automatic model_reset();
    m_key_cur.delete();
    m_data.delete();
    exp_q.delete();
    m_key_full = '0;
    m_key_ok   = 1'b0;
    m_hold     = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    #4;
    if (blk_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_miss++;
        $display("FAIL unexpected_block: got data %h with no block expected", blk_data);
      end else begin
        automatic logic [255:0] e = exp_q.pop_front();
        check("blk_data", 256'(blk_data), 256'(e[255:128]));
        check("blk_key", 256'(blk_key), 256'(e[127:0]));
      end
    end
  end

  // ---------------- driver tasks (start and end just after a falling edge) ----------------
  task automatic idle();
    @(negedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit k);
    bit acc;
    bit key_start = 1'b0;
    bit key_done  = 1'b0;
    bit blk_done  = 1'b0;
    in_data  = b;
    in_key   = k;
    in_valid = 1'b1;
    #1;
    acc = pred_ready(k);
    check(k ? "in_ready_key" : "in_ready_data", 256'(in_ready), 256'(acc));
    if (acc) begin
      if (k) begin
        if (m_key_cur.size() == 0) begin
          m_key_ok  = 1'b0;
          key_start = 1'b1;
        end
        m_key_cur.push_back(b);
        if (m_key_cur.size() == KB1) begin
          m_key_full = key_cur_val();
          m_key_ok   = 1'b1;
          m_key_cur.delete();
          key_done   = 1'b1;
        end
      end else begin
        m_data.push_back(b);
        if (m_data.size() == 16) begin
          exp_q.push_back({data_val(), m_key_full});
          m_data.delete();
          m_hold   = 1'b1;
          blk_done = 1'b1;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    if (key_start) check("key_ok_cleared", 256'(key_ok), 256'(0));
    if (key_done) begin
      check("key_ok_set", 256'(key_ok), 256'(1));
      check("blk_key_loaded", 256'(blk_key), 256'(m_key_full));
    end
    if (blk_done) check("blk_valid_rise", 256'(blk_valid), 256'(1));
  endtask

  task automatic accept_block(input int hold);
    check("blk_valid_offered", 256'(blk_valid), 256'(m_hold));
    for (int i = 0; i < hold; i++) begin
      check("bp_blk_valid", 256'(blk_valid), 256'(1));
      check("bp_blk_data", 256'(blk_data), 256'(exp_q[0][255:128]));
      check("bp_blk_key", 256'(blk_key), 256'(exp_q[0][127:0]));
      check("bp_in_ready", 256'(in_ready), 256'(0));
      idle();
    end
    blk_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk_ready = 1'b0;
    m_hold    = 1'b0;
    #1;
    check("blk_valid_fall", 256'(blk_valid), 256'(0));
    in_key = 1'b0;
    #1;
    check("in_ready_after_accept", 256'(in_ready), 256'(m_key_ok));
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    blk_ready = 1'b0;
    in_key    = 1'b1;
    #1;
    check("rst_in_ready_key", 256'(in_ready), 256'(0));
    in_key = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_in_ready", 256'(in_ready), 256'(0));
    check("rst_blk_valid", 256'(blk_valid), 256'(0));
    check("rst_key_ok", 256'(key_ok), 256'(0));
    check("rst_blk_data", 256'(blk_data), 256'(0));
    check("rst_blk_key", 256'(blk_key), 256'(0));
    rst = 1'b0;
    model_reset();
  endtask

  task automatic random_key();
    for (int i = 0; i < KB1; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);
  endtask

  task automatic random_block();
    for (int i = 0; i < 16; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    do_reset();

    // Plaintext before any key is refused and leaves the block register alone.
    for (int i = 0; i < 3; i++) send_byte(8'(8'h40 + i), 1'b0);
    check("data_before_key_blk", 256'(blk_data), 256'(0));

    // FIPS-197 AES-128 vector with a key change attempted mid-block.
    for (int i = 0; i < 16; i++) send_byte(8'(i), 1'b1);
    check("fips_key", 256'(blk_key), 256'(128'h000102030405060708090a0b0c0d0e0f));
    for (int i = 0; i < 5; i++) send_byte(8'(i * 17), 1'b0);
    send_byte(8'ha5, 1'b1);
    for (int i = 5; i < 16; i++) send_byte(8'(i * 17), 1'b0);
    check("fips_data", 256'(blk_data), 256'(128'h00112233445566778899aabbccddeeff));
    accept_block(10);

    // A new key byte after the block is accepted and drops key_ok.
    send_byte(8'h2b, 1'b1);
    for (int i = 1; i < KB1; i++) send_byte(8'($urandom_range(0, 255)), 1'b1);

    // Randomized mix of key bytes, data bytes, idles and downstream accepts.
    for (int op = 0; op < 500; op++) begin
      automatic int r = $urandom_range(0, 99);
      automatic logic [7:0] b = 8'($urandom_range(0, 255));
      if (m_hold) begin
        if (r < 60) accept_block($urandom_range(0, 3));
        else send_byte(b, r[0]);
      end else if (m_key_cur.size() > 0 || !m_key_ok) begin
        if (r < 85) send_byte(b, 1'b1);
        else if (r < 95) send_byte(b, 1'b0);
        else idle();
      end else begin
        if (r < 5) send_byte(b, 1'b1);
        else if (r < 90) send_byte(b, 1'b0);
        else idle();
      end
    end

    // Bring the model to a clean point, then reset after 9 data bytes.
    if (m_hold) accept_block(0);
    if (m_data.size() > 0) begin
      while (m_data.size() > 0) send_byte(8'($urandom_range(0, 255)), 1'b0);
      accept_block(1);
    end
    while (m_key_cur.size() > 0) send_byte(8'($urandom_range(0, 255)), 1'b1);
    if (!m_key_ok) random_key();
    for (int i = 0; i < 9; i++) send_byte(8'($urandom_range(0, 255)), 1'b0);
    do_reset();
    random_key();
    random_block();
    accept_block(2);

    // AES-256 key load on the N=3 instance.
    rst_3 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      in_data_3  = 8'(i);
      in_key_3   = 1'b1;
      in_valid_3 = 1'b1;
      #1;
      check("n3_in_ready_key", 256'(in_ready_3), 256'(1));
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    in_valid_3 = 1'b0;
    check("n3_key_ok", 256'(key_ok_3), 256'(1));
    check("n3_blk_key", blk_key_3,
          256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f);
    for (int i = 0; i < 16; i++) begin
      in_data_3  = 8'(i * 17);
      in_key_3   = 1'b0;
      in_valid_3 = 1'b1;
      #1;
      check("n3_in_ready_data", 256'(in_ready_3), 256'(1));
      @(posedge clk);
      @(negedge clk);
      #1;
    end
    in_valid_3 = 1'b0;
    check("n3_blk_valid", 256'(blk_valid_3), 256'(1));
    check("n3_blk_data", 256'(blk_data_3), 256'(128'h00112233445566778899aabbccddeeff));
    blk_ready_3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    blk_ready_3 = 1'b0;
    #1;
    check("n3_blk_valid_fall", 256'(blk_valid_3), 256'(0));

    repeat (3) idle();
    check("exp_q_drained", 256'(exp_q.size()), 256'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Bounded run time: a stalled sequence still reports and ends.
  initial begin
    #400000;
    n_miss++;
    $display("FAIL timeout: got no completion expected finish within 400000 time units");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1);
  end

endmodule
